// File: rtl/apb2axi_pkg.sv
// Shared types, widths and response helpers for the APB-to-AXI bridge read path.
// Latency: none (declarations only).
// Backpressure: n/a.
package apb2axi_pkg;

    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam int TAG_NUM    = 16;
    localparam int TAG_W      = $clog2(TAG_NUM);

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        RT_IDLE   = 1'b0,
        RT_ACTIVE = 1'b1
    } rd_tag_state_e;

    // Per-tag burst context: FSM state, beats accepted so far, worst response seen
    typedef struct packed {
        rd_tag_state_e state;
        logic [7:0]    cnt;
        logic [1:0]    worst;
    } rd_tag_ctx_t;

    // One read-data FIFO entry per accepted beat
    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [AXI_DATA_W-1:0] data;
        logic                  last;
        logic [1:0]            resp;
    } rdf_entry_t;

    // One completion FIFO entry per finished burst
    typedef struct packed {
        logic             is_write;
        logic [TAG_W-1:0] tag;
        logic [1:0]       resp;
        logic             error;
        logic [7:0]       num_beats;
    } completion_entry_t;

    localparam int RDF_W = $bits(rdf_entry_t);
    localparam int CPL_W = $bits(completion_entry_t);

    localparam rd_tag_ctx_t RD_TAG_CTX_RST = '{state: RT_IDLE, cnt: 8'd0, worst: AXI_RESP_OKAY};

    // Worst-of merge: DECERR beats SLVERR beats OKAY; EXOKAY counts as OKAY
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        if (a == AXI_RESP_DECERR || b == AXI_RESP_DECERR) begin
            return AXI_RESP_DECERR;
        end else if (a == AXI_RESP_SLVERR || b == AXI_RESP_SLVERR) begin
            return AXI_RESP_SLVERR;
        end else begin
            return AXI_RESP_OKAY;
        end
    endfunction

endpackage

// File: rtl/apb2axi_rd_tag_ctx.sv
// Per-tag read burst context store: TAG_NUM entries, one async read port, one write port.
// Latency: read is combinational; a write is visible on the cycle after wr_en.
// Backpressure: none; the owner decides when to write.
module apb2axi_rd_tag_ctx
    import apb2axi_pkg::*;
(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [TAG_W-1:0]   rd_tag,
    output rd_tag_ctx_t        rd_ctx,
    input  logic               wr_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  rd_tag_ctx_t        wr_ctx,
    output logic [TAG_NUM-1:0] tag_active
);

    rd_tag_ctx_t ctx_q [TAG_NUM];

    // Context array: cleared by reset so a burst cut by reset leaves no trace
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int t = 0; t < TAG_NUM; t++) begin
                ctx_q[t] <= RD_TAG_CTX_RST;
            end
        end else if (wr_en) begin
            ctx_q[wr_tag] <= wr_ctx;
        end
    end

    assign rd_ctx = ctx_q[rd_tag];

    // A tag is active between its first non-last beat and its last beat
    always_comb begin
        tag_active = '0;
        for (int t = 0; t < TAG_NUM; t++) begin
            tag_active[t] = (ctx_q[t].state == RT_ACTIVE);
        end
    end

endmodule

// File: rtl/apb2axi_rd_resp_collector.sv
// AXI R-channel sink: tags each beat into the read-data FIFO, one completion per burst on RLAST.
// Latency: rdf push in the accept cycle; completion push registered, 1 cycle after the last beat.
// Backpressure: rready drops on rdf_full, cpl_full and in the completion push cycle. Option: APB2AXI_RLEN_CHECK_EN.
module apb2axi_rd_resp_collector
    import apb2axi_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [AXI_ID_W-1:0]   rid,
    input  logic [AXI_DATA_W-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  rdf_wr_en,
    output logic [RDF_W-1:0]      rdf_wr_data,
    input  logic                  rdf_full,
    output logic                  cpl_wr_en,
    output logic [CPL_W-1:0]      cpl_wr_data,
    input  logic                  cpl_full,
    output logic [TAG_NUM-1:0]    tag_active
`ifdef APB2AXI_RLEN_CHECK_EN
    ,
    output logic [TAG_W-1:0]      dir_rd_tag,
    input  logic [7:0]            dir_rd_len
`endif
);

    logic              aresetn_q;
    logic              acc;
    logic [TAG_W-1:0]  tag;
    rd_tag_ctx_t       rd_ctx;
    rd_tag_ctx_t       wr_ctx;
    rd_tag_state_e     state_nxt;
    logic [1:0]        merged_resp;
    logic [7:0]        cnt_inc;
    logic              len_err;
    rdf_entry_t        rdf_entry;
    completion_entry_t cpl_nxt;

    // Hold rready low until the first clock edge after reset release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aresetn_q <= 1'b0;
        end else begin
            aresetn_q <= 1'b1;
        end
    end

    // The completion push cycle blocks the next beat so last pushes never collide
    assign rready = aresetn_q & ~rdf_full & ~cpl_full & ~cpl_wr_en;
    assign acc    = rvalid & rready;
    assign tag    = rid[TAG_W-1:0];

`ifdef APB2AXI_RLEN_CHECK_EN
    assign dir_rd_tag = tag;
`endif

    apb2axi_rd_tag_ctx u_tag_ctx (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .rd_tag     (tag),
        .rd_ctx     (rd_ctx),
        .wr_en      (acc),
        .wr_tag     (tag),
        .wr_ctx     (wr_ctx),
        .tag_active (tag_active)
    );

    // Beat pass-through into the read-data FIFO, same cycle as the accept
    always_comb begin
        rdf_entry      = '0;
        rdf_entry.tag  = tag;
        rdf_entry.data = rdata;
        rdf_entry.last = rlast;
        rdf_entry.resp = rresp;
    end

    assign rdf_wr_en   = acc;
    assign rdf_wr_data = rdf_entry;

    // Response merge, saturating beat count and optional length check for the current beat
    always_comb begin
        len_err = 1'b0;
`ifdef APB2AXI_RLEN_CHECK_EN
        // cnt is the 0-based index of this beat; the last beat must sit at index len
        if (rlast) begin
            len_err = (rd_ctx.cnt != dir_rd_len);
        end else begin
            len_err = (rd_ctx.cnt == dir_rd_len);
        end
`endif
        merged_resp = resp_merge(rd_ctx.worst, rresp);
        if (len_err && merged_resp != AXI_RESP_DECERR) begin
            merged_resp = AXI_RESP_SLVERR;
        end
        cnt_inc = (rd_ctx.cnt == 8'hFF) ? 8'hFF : rd_ctx.cnt + 8'd1;
    end

    // Per-tag FSM next state; the context is only written on an accepted beat
    always_comb begin
        state_nxt = rd_ctx.state;
        case (rd_ctx.state)
            RT_IDLE:   state_nxt = rlast ? RT_IDLE : RT_ACTIVE;
            RT_ACTIVE: state_nxt = rlast ? RT_IDLE : RT_ACTIVE;
            default:   state_nxt = RT_IDLE;
        endcase

        wr_ctx = RD_TAG_CTX_RST;
        if (!rlast) begin
            wr_ctx.state = state_nxt;
            wr_ctx.cnt   = cnt_inc;
            wr_ctx.worst = merged_resp;
        end
    end

    // Completion payload built from the context plus the last beat itself
    always_comb begin
        cpl_nxt           = '0;
        cpl_nxt.is_write  = 1'b0;
        cpl_nxt.tag       = tag;
        cpl_nxt.resp      = merged_resp;
        cpl_nxt.error     = merged_resp[1];
        cpl_nxt.num_beats = cnt_inc;
    end

    // Completion register: one-cycle push following each last-beat accept
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cpl_wr_en   <= 1'b0;
            cpl_wr_data <= '0;
        end else begin
            cpl_wr_en <= acc & rlast;
            if (acc && rlast) begin
                cpl_wr_data <= cpl_nxt;
            end
        end
    end

endmodule
